// File: rtl/cpu_pkg.sv
// Shared definitions for the boot-time program loader and its memory port.
package cpu_pkg;

  localparam int MEM_AW = 8;
  localparam int MEM_DW = 16;

  // Default frame start byte.
  localparam logic [7:0] HEADER_DEF = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_COUNT,
    ST_HI,
    ST_LO,
    ST_WRITE,
    ST_CHK,
    ST_RUN
  } loader_state_t;

endpackage

// File: rtl/frame_timer.sv
// Idle-cycle counter for the loader. It counts cycles while enabled and
// returns to zero on clear. o_expired is high during the LIMIT-th
// consecutive enabled cycle, so the owner can abort on that cycle's edge.
module frame_timer #(
  parameter int unsigned LIMIT = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] r_count;

  assign o_expired = i_enable && (r_count == LAST);

  // Count enabled cycles, saturating at the expiry point.
  // NOTE: state registers take the async reset; sequential logic uses
  // non-blocking assignments only so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + W'(1);
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot-time program loader: receives a HEADER/ADDR/COUNT/data/CHK byte
// frame, writes assembled 16-bit words to memory while holding the CPU,
// then releases the CPU when the frame checksum matches.
module program_loader
  import cpu_pkg::*;
#(
  parameter logic [7:0]  HEADER      = HEADER_DEF,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [MEM_DW-1:0] mem_wdata,
  output logic              mem_wr,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  loader_state_t     r_state;
  logic              r_hold;
  logic              r_done;
  logic              r_err;
  logic              r_mem_wr;
  logic [MEM_AW-1:0] r_addr;
  logic [MEM_DW-1:0] r_wdata;
  logic [7:0]        r_hi;
  logic [8:0]        r_count;   // words remaining, 1..256
  logic [7:0]        r_chk;     // running XOR of ADDR, COUNT and data bytes

  logic w_accept;
  logic w_is_header;
  logic w_timer_clear;
  logic w_timeout;

  // The only cycle the loader stalls the byte source is the memory write.
  assign byte_ready  = (r_state != ST_WRITE);
  assign w_accept    = byte_valid && byte_ready;
  assign w_is_header = (byte_i == HEADER);

  // The idle timer only runs while waiting for an in-frame byte.
  assign w_timer_clear = w_accept || (r_state inside {ST_IDLE, ST_RUN, ST_WRITE});

  frame_timer #(
    .LIMIT (TIMEOUT_CYC)
  ) u_frame_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_timer_clear),
    .i_enable  (!w_timer_clear),
    .o_expired (w_timeout)
  );

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wr    = r_mem_wr;
  assign cpu_hold  = r_hold;
  assign load_done = r_done;
  assign load_err  = r_err;

  // Frame sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_hold   <= 1'b1;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_mem_wr <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_hi     <= '0;
      r_count  <= '0;
      r_chk    <= '0;
    end else begin
      r_mem_wr <= 1'b0;
      if (w_timeout) begin
        r_state <= ST_IDLE;
        r_err   <= 1'b1;
        r_hold  <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE, ST_RUN: begin
            if (w_accept && w_is_header) begin
              r_state <= ST_ADDR;
              r_done  <= 1'b0;
              r_err   <= 1'b0;
              r_hold  <= 1'b1;
              r_chk   <= '0;
            end
          end
          ST_ADDR: begin
            if (w_accept) begin
              r_addr  <= byte_i;
              r_chk   <= r_chk ^ byte_i;
              r_state <= ST_COUNT;
            end
          end
          ST_COUNT: begin
            if (w_accept) begin
              r_count <= (byte_i == 8'd0) ? 9'd256 : {1'b0, byte_i};
              r_chk   <= r_chk ^ byte_i;
              r_state <= ST_HI;
            end
          end
          ST_HI: begin
            if (w_accept) begin
              r_hi    <= byte_i;
              r_chk   <= r_chk ^ byte_i;
              r_state <= ST_LO;
            end
          end
          ST_LO: begin
            if (w_accept) begin
              r_wdata  <= {r_hi, byte_i};
              r_chk    <= r_chk ^ byte_i;
              r_mem_wr <= 1'b1;
              r_state  <= ST_WRITE;
            end
          end
          ST_WRITE: begin
            r_addr  <= r_addr + MEM_AW'(1);
            r_count <= r_count - 9'd1;
            r_state <= (r_count == 9'd1) ? ST_CHK : ST_HI;
          end
          ST_CHK: begin
            if (w_accept) begin
              if (byte_i == r_chk) begin
                r_state <= ST_RUN;
                r_done  <= 1'b1;
                r_hold  <= 1'b0;
              end else begin
                r_state <= ST_IDLE;
                r_err   <= 1'b1;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed-plus-random bench for program_loader. A behavioural memory image
// and frame checksum are computed here from the frame rules; DUT writes are
// captured from the memory port and compared against that image.
module tb_program_loader;

  localparam logic [7:0] HDR = 8'hA5;
  localparam int         TO  = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  byte_i;
  logic        byte_valid;
  logic        byte_ready;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_wr;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_count = 0;
  int exp_wr = 0;

  logic [15:0] ref_mem [256];
  logic [15:0] dut_mem [256];
  logic [15:0] wq [$];

  program_loader #(
    .HEADER      (HDR),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_i     (byte_i),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wr     (mem_wr),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  // Capture whatever the DUT writes into its memory port.
  always @(posedge clk) begin
    if (mem_wr === 1'b1) begin
      dut_mem[mem_addr] = mem_wdata;
      wr_count++;
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one byte (after an optional idle gap) and return at the negedge
  // following its acceptance.
  task automatic send(input logic [7:0] b, input int gap);
    int guard = 0;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_i     = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 8) check("byte_ready_wait", 32'(byte_ready), 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic fill_random(input int n);
    wq.delete();
    repeat (n) wq.push_back(16'($urandom));
  endtask

  // Send a whole frame carrying the words in wq; chk_val is the CHK byte sent.
  task automatic run_frame(input logic [7:0] a, input logic [7:0] c,
                           input logic [7:0] chk_val, input bit use_model_chk,
                           input bit gaps);
    int n;
    logic [7:0] ad;
    logic [7:0] chk;
    logic [7:0] sent;
    logic [15:0] w;
    bit good;
    n   = (c == 8'd0) ? 256 : int'(c);
    ad  = a;
    chk = a ^ c;
    send(HDR, gaps ? int'($urandom_range(0, 3)) : 0);
    check("hold_after_header", 32'(cpu_hold), 32'd1);
    check("done_after_header", 32'(load_done), 32'd0);
    check("err_after_header", 32'(load_err), 32'd0);
    send(a, gaps ? int'($urandom_range(0, 3)) : 0);
    send(c, gaps ? int'($urandom_range(0, 3)) : 0);
    for (int i = 0; i < n; i++) begin
      w = wq[i];
      send(w[15:8], gaps ? int'($urandom_range(0, 3)) : 0);
      send(w[7:0], gaps ? int'($urandom_range(0, 3)) : 0);
      chk ^= w[15:8] ^ w[7:0];
      check("mem_wr_pulse", 32'(mem_wr), 32'd1);
      check("mem_addr", 32'(mem_addr), 32'(ad));
      check("mem_wdata", 32'(mem_wdata), 32'(w));
      ref_mem[ad] = w;
      exp_wr++;
      ad = ad + 8'd1;
    end
    sent = use_model_chk ? chk : chk_val;
    good = (sent == chk);
    send(sent, gaps ? int'($urandom_range(0, 3)) : 0);
    check("load_done_after_chk", 32'(load_done), good ? 32'd1 : 32'd0);
    check("cpu_hold_after_chk", 32'(cpu_hold), good ? 32'd0 : 32'd1);
    check("load_err_after_chk", 32'(load_err), good ? 32'd0 : 32'd1);
    check("write_count", 32'(wr_count), 32'(exp_wr));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_byte_ready"}, 32'(byte_ready), 32'd1);
    check({tag, "_mem_wr"}, 32'(mem_wr), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_load_done"}, 32'(load_done), 32'd0);
    check({tag, "_load_err"}, 32'(load_err), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 16'hDEAD;
      dut_mem[i] = 16'hDEAD;
    end
    rst_n      = 1'b0;
    byte_valid = 1'b0;
    byte_i     = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single word at 0xC9, good checksum 0x94.
    wq.delete();
    wq.push_back(16'h95C9);
    run_frame(8'hC9, 8'h01, 8'h94, 1'b0, 1'b0);

    // Two words wrapping from 0xFF to 0x00.
    wq.delete();
    wq.push_back(16'h1122);
    wq.push_back(16'h3344);
    run_frame(8'hFF, 8'h02, 8'hFF ^ 8'h02 ^ 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44, 1'b0, 1'b0);

    // Same single-word frame with a wrong checksum: word still written.
    wq.delete();
    wq.push_back(16'h95C9);
    run_frame(8'hC9, 8'h01, 8'h00, 1'b0, 1'b0);

    // Random short frames with idle gaps between bytes.
    for (int f = 0; f < 4; f++) begin
      logic [7:0] a;
      logic [7:0] c;
      a = 8'($urandom);
      c = 8'($urandom_range(1, 6));
      fill_random(int'(c));
      run_frame(a, c, 8'h00, 1'b1, 1'b1);
    end

    // Timeout: header and address, then silence.
    send(HDR, 0);
    send(8'h10, 0);
    repeat (TO - 1) @(negedge clk);
    check("err_before_timeout", 32'(load_err), 32'd0);
    @(negedge clk);
    check("err_at_timeout", 32'(load_err), 32'd1);
    check("hold_at_timeout", 32'(cpu_hold), 32'd1);
    check("ready_in_idle", 32'(byte_ready), 32'd1);
    send(8'h10, 0);
    check("idle_ignores_byte_err", 32'(load_err), 32'd1);
    check("idle_ignores_byte_done", 32'(load_done), 32'd0);
    fill_random(3);
    run_frame(8'($urandom), 8'd3, 8'h00, 1'b1, 1'b0);

    // In RUN a non-header byte is ignored; a 256-word frame then reloads.
    send(8'h00, 0);
    check("run_ignores_byte_hold", 32'(cpu_hold), 32'd0);
    check("run_ignores_byte_done", 32'(load_done), 32'd1);
    fill_random(256);
    run_frame(8'($urandom), 8'd0, 8'h00, 1'b1, 1'b0);

    // Reset asserted during the write cycle of a frame.
    send(HDR, 0);
    send(8'h40, 0);
    send(8'h02, 0);
    send(8'hBE, 0);
    send(8'hEF, 0);
    check("write_cycle_before_reset", 32'(mem_wr), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("midframe_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("no_partial_write", 32'(wr_count), 32'(exp_wr));

    for (int i = 0; i < 256; i++) begin
      check($sformatf("mem_image_%0d", i), 32'(dut_mem[i]), 32'(ref_mem[i]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program loader sitting directly upstream of the 256x16 unified memory. It accepts a byte stream (UART receiver or host bench), assembles 16-bit words, writes them into memory while holding the CPU in reset, checks a frame checksum, then releases the CPU. While `cpu_hold` is high it owns the memory write port; the top level muxes `mem_addr`/`mem_wdata`/`mem_wr` ahead of the CPU's address mux and drives `PC_clr` from `cpu_hold`.

## Interface
- `HEADER`, 8'hA5, frame start byte
- `TIMEOUT_CYC`, 1_000_000, max idle cycles between bytes inside a frame before abort
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `byte_i`  in  8  incoming byte
- `byte_valid`  in  1  `byte_i` valid
- `byte_ready`  out  1  loader can accept a byte this cycle
- `mem_addr`  out  8  memory write address
- `mem_wdata`  out  16  memory write data
- `mem_wr`  out  1  single-cycle memory write strobe
- `cpu_hold`  out  1  CPU held in reset / loader owns memory
- `load_done`  out  1  last frame loaded with good checksum (level)
- `load_err`  out  1  last frame failed (checksum or timeout) (level)

## Operation
- Frame: `HEADER`, ADDR, COUNT, then COUNT words each sent high byte then low byte, then CHK. COUNT=0 means 256 words.
- CHK = XOR of ADDR, COUNT and every data byte; HEADER excluded.
- Byte accepted on rising `clk` when `byte_valid && byte_ready`.
- States: IDLE, ADDR, COUNT, HI, LO, WRITE, CHK, RUN.
- IDLE: `byte_ready`=1; bytes other than `HEADER` consumed and ignored; `HEADER` -> ADDR, clears `load_done`/`load_err`, sets `cpu_hold`.
- ADDR: latch start address -> COUNT. COUNT: latch word count -> HI.
- HI: latch high byte -> LO. LO: latch low byte -> WRITE.
- WRITE: `byte_ready`=0, `mem_wr`=1 for exactly this cycle with current address/word; address increments mod 256 (0xFF -> 0x00); remaining count decrements; -> HI if words remain, else CHK.
- CHK: byte equals running XOR -> RUN with `load_done`=1, `cpu_hold`=0; mismatch -> IDLE with `load_err`=1, `cpu_hold` stays 1.
- RUN: `byte_ready`=1; non-header bytes ignored; `HEADER` restarts a load exactly as from IDLE (CPU re-held).
- Timeout: in ADDR..LO or CHK, `TIMEOUT_CYC` consecutive cycles with no accepted byte -> IDLE, `load_err`=1, `cpu_hold`=1. Counter clears on each accepted byte and in IDLE/RUN/WRITE.
- Words already written before an error remain in memory.

## Timing
- Reset values: `cpu_hold`=1, `byte_ready`=1 (state IDLE), `mem_wr`=0, `mem_addr`=0, `mem_wdata`=0, `load_done`=0, `load_err`=0.
- Reset asserted mid-frame: immediate return to IDLE, `mem_wr` drops asynchronously; no partial write.
- `mem_wr` is high in the cycle after the low byte is accepted; `mem_addr`/`mem_wdata` stable that whole cycle.
- Minimum frame length in cycles: 3 + 3*COUNT + 1 at back-to-back valid.
- `cpu_hold` falls and `load_done` rises in the cycle after CHK acceptance; `cpu_hold` rises in the cycle after HEADER acceptance.
- All outputs registered; `byte_ready` is decoded from registered state only.

## Structure
- Shared package `cpu_pkg`: `loader_state_t` enum, `MEM_AW`=8, `MEM_DW`=16, default `HEADER` constant.
- One sub-module: `frame_timer` (loadable idle counter, clear/enable in, `expired` out).

## Test plan
- Reset, then A5 C9 01 95 C9 CHK=0x94 -> one `mem_wr` at addr 0xC9 data 0x95C9; `load_done`=1, `cpu_hold`=0 one cycle after CHK.
- A5 FF 02 11 22 33 44 CHK=(FF^02^11^22^33^44) -> writes 0xFF=0x1122, 0x00=0x3344 (wrap).
- Same frame as first test with CHK=0x00 -> write occurs, `load_err`=1, `load_done`=0, `cpu_hold` stays 1.
- A5 10 then silence `TIMEOUT_CYC` cycles -> `load_err`=1, state IDLE; next `HEADER` clears `load_err`.
- In RUN, send 0x00 then A5 -> 0x00 ignored, `cpu_hold` rises one cycle after A5; COUNT=0 frame writes 256 words.
- Assert `rst_n`=0 while in WRITE -> `mem_wr` low immediately, all outputs at reset values.
